replicacao_blocos: RTL and testbench
====================================

// Module: replicacao_blocos
// PURPOSE
//  Nearest-neighbour upscaler, inverse of the block-averaging downscaler. Reads a LARGURAxALTURA
//  8-bit grayscale image from ROM and writes each source pixel as a fator x fator block into the
//  frame RAM, giving a (LARGURA*fator)x(ALTURA*fator) image. Sits in the coprocessor ULA.
//  Started by the instruction decoder through a start/done handshake.
// PARAMETERS
//  LARGURA  160  source width, pixels
//  ALTURA   120  source height, pixels
//  ROM_LAT  2    cycles from a rom_addr update to pixel_rom being valid for sampling (legal 1..3)
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-low reset
//  start       in   1   start request; sampled only in IDLE/DONE
//  fator       in   3   zoom factor; latched at start; legal 1..4
//  pixel_rom   in   8   ROM read data
//  rom_addr    out  19  ROM read address = src_y*LARGURA + src_x
//  ram_wraddr  out  19  RAM write address
//  ram_data    out  8   RAM write data
//  ram_wren    out  1   RAM write enable; one pixel written per high cycle
//  busy        out  1   high from start acceptance until done
//  done        out  1   level; high after completion until the next accepted start
//  erro        out  1   level; high when the latched fator is illegal; cleared by the next start
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters and latched fator 0. Reset mid-run aborts the run
//    immediately. No ram_wren after reset deasserts until a new start.
//  - States: IDLE -> FETCH -> WAIT -> WRITE -> (FETCH | DONE); DONE -> FETCH on start.
//  - IDLE/DONE with start=1: latch fator; clear done and erro; set busy; src_x=src_y=0.
//    - fator 0 or >4: go to DONE with erro=1, busy=0, and no RAM writes.
//    - Otherwise go to FETCH.
//  - start while busy is ignored. fator changes while busy have no effect.
//  - FETCH, 1 cycle: rom_addr <= src_y*LARGURA + src_x.
//  - WAIT, ROM_LAT cycles: on the last cycle, pixel_rom is captured into the pixel register.
//  - WRITE, fator^2 consecutive cycles, ram_wren=1 on each:
//    - ram_data = captured pixel.
//    - ram_wraddr = (src_y*fator + sub_y)*(LARGURA*fator) + src_x*fator + sub_x.
//    - sub_x is the inner loop, sub_y the outer loop, each 0..fator-1.
//    - ram_wraddr, ram_data and ram_wren are registered and change together.
//  - After WRITE: src_x increments; at LARGURA-1 it wraps to 0 and src_y increments.
//    After the last pixel (src_x=LARGURA-1, src_y=ALTURA-1) go to DONE: done=1, busy=0.
//  - ram_wren=0 in every state except WRITE.
//  - Cycle count: done rises exactly LARGURA*ALTURA*(1+ROM_LAT+fator^2) cycles after the
//    start-accept edge.
//  - Total writes = LARGURA*ALTURA*fator^2, each output address exactly once; the write order is
//    block order, not raster order.
//  - Widths:
//    - Maximum address 640*480-1 = 307199, fits in 19 bits.
//    - All products are computed at 19 bits or wider; no truncation.
//    - fator=1 is a straight copy with ram_wraddr == rom_addr.
// TESTING
//  - fator=2, ROM_LAT=2, ROM[a]=a[7:0]: 76800 writes; RAM[(2y+j)*320+2x+i] = ROM[y*160+x] for
//    all i,j in {0,1}; done after exactly 134400 cycles; no address written twice.
//  - fator=4: 307200 writes; last write to address 307199 carries ROM[19199]; done exactly
//    19200*19 = 364800 cycles after start.
//  - fator=1: 19200 writes; the RAM image equals the ROM image; ram_wraddr == rom_addr on every
//    write.
//  - fator=0, then fator=5: done=1 and erro=1 two cycles after start; zero ram_wren pulses;
//    a following start with fator=2 clears erro and completes normally.
//  - Pulse start while busy and toggle fator mid-run: no effect. Reset asserted mid-WRITE:
//    ram_wren, busy and done drop asynchronously; a new start with fator=3 yields a correct
//    480x360 image.
//  - Back-to-back: assert start in the same cycle done is observed high. done clears on the next
//    edge; the second run produces the correct image with an identical cycle count.

Source files
------------

// File: rtl/replicacao_blocos.sv
//------------------------------------------------------------------------------
// Module      : replicacao_blocos
// Description : Nearest-neighbour upscaler. Reads a LARGURA x ALTURA 8-bit
//               grayscale image from ROM. Writes each source pixel into frame
//               RAM as a fator x fator block, so the result is a
//               (LARGURA*fator) x (ALTURA*fator) image. Started through a
//               start/done handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk         in   1   clock
//   reset       in   1   asynchronous, active-low reset
//   start       in   1   start request, sampled only in IDLE/DONE
//   fator       in   3   zoom factor, latched at start, legal 1..4
//   pixel_rom   in   8   ROM read data
//   rom_addr    out  19  ROM read address = src_y*LARGURA + src_x
//   ram_wraddr  out  19  RAM write address
//   ram_data    out  8   RAM write data
//   ram_wren    out  1   RAM write enable, one pixel per high cycle
//   busy        out  1   high from start acceptance until completion
//   done        out  1   high after completion until the next accepted start
//   erro        out  1   high when the latched fator is illegal
//------------------------------------------------------------------------------
`default_nettype none

module replicacao_blocos #(
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120,
  parameter int ROM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  fator,
  input  logic [7:0]  pixel_rom,
  output logic [18:0] rom_addr,
  output logic [18:0] ram_wraddr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  localparam int c_x_w = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int c_y_w = (ALTURA > 1) ? $clog2(ALTURA) : 1;

  localparam logic [c_x_w-1:0] c_x_last   = c_x_w'(LARGURA - 1);
  localparam logic [c_y_w-1:0] c_y_last   = c_y_w'(ALTURA - 1);
  localparam logic [c_x_w-1:0] c_x_one    = c_x_w'(1);
  localparam logic [c_y_w-1:0] c_y_one    = c_y_w'(1);
  // WAIT counts down from ROM_LAT-1 and captures the pixel when it reaches 0.
  localparam logic [1:0]       c_wait_init = 2'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_x_w-1:0]   r_src_x;
  logic [c_y_w-1:0]   r_src_y;
  logic [2:0]         r_fator;
  logic [2:0]         r_sub_x;
  logic [2:0]         r_sub_y;
  logic [1:0]         r_wait_cnt;

  logic               w_fator_ok;
  logic               w_last_src;
  logic               w_last_sub_x;
  logic               w_last_sub_y;
  logic [18:0]        w_rom_addr;

  // Output address of one sub-pixel. Every intermediate is 19 bits wide,
  // which covers the largest frame of 640x480.
  function automatic logic [18:0] calc_wraddr(
    input logic [c_x_w-1:0] sx,
    input logic [c_y_w-1:0] sy,
    input logic [2:0]       ux,
    input logic [2:0]       uy,
    input logic [2:0]       f
  );
    logic [18:0] line;
    logic [18:0] col;
    logic [18:0] width;
    line  = 19'(sy) * 19'(f) + 19'(uy);
    col   = 19'(sx) * 19'(f) + 19'(ux);
    width = 19'(LARGURA) * 19'(f);
    return line * width + col;
  endfunction

  always_comb begin
    w_fator_ok   = (r_fator != 3'd0) && (r_fator <= 3'd4);
    w_last_src   = (r_src_x == c_x_last) && (r_src_y == c_y_last);
    w_last_sub_x = (r_sub_x == (r_fator - 3'd1));
    w_last_sub_y = (r_sub_y == (r_fator - 3'd1));
    w_rom_addr   = 19'(r_src_y) * 19'(LARGURA) + 19'(r_src_x);
  end

  // ram_data doubles as the captured-pixel register. It is loaded on the
  // last WAIT cycle and held for the whole block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_src_x    <= '0;
      r_src_y    <= '0;
      r_fator    <= '0;
      r_sub_x    <= '0;
      r_sub_y    <= '0;
      r_wait_cnt <= '0;
      rom_addr   <= '0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      erro       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_fator <= fator;
            done    <= 1'b0;
            erro    <= 1'b0;
            busy    <= 1'b1;
            r_src_x <= '0;
            r_src_y <= '0;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          // Legality is judged on the latched factor. A bad factor ends the
          // run here, before any ROM read or RAM write happens.
          if (!w_fator_ok) begin
            erro    <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            rom_addr   <= w_rom_addr;
            r_wait_cnt <= c_wait_init;
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            ram_data   <= pixel_rom;
            ram_wren   <= 1'b1;
            ram_wraddr <= calc_wraddr(r_src_x, r_src_y, 3'd0, 3'd0, r_fator);
            r_sub_x    <= 3'd0;
            r_sub_y    <= 3'd0;
            r_state    <= S_WRITE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end

        S_WRITE: begin
          // The outputs already show the current sub-pixel. Here we advance
          // to the next one, with sub_x as the inner loop.
          if (w_last_sub_x) begin
            if (w_last_sub_y) begin
              ram_wren <= 1'b0;
              if (w_last_src) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_state <= S_FETCH;
                if (r_src_x == c_x_last) begin
                  r_src_x <= '0;
                  r_src_y <= r_src_y + c_y_one;
                end else begin
                  r_src_x <= r_src_x + c_x_one;
                end
              end
            end else begin
              r_sub_x    <= 3'd0;
              r_sub_y    <= r_sub_y + 3'd1;
              ram_wraddr <= calc_wraddr(r_src_x, r_src_y, 3'd0,
                                        r_sub_y + 3'd1, r_fator);
            end
          end else begin
            r_sub_x    <= r_sub_x + 3'd1;
            ram_wraddr <= calc_wraddr(r_src_x, r_src_y, r_sub_x + 3'd1,
                                      r_sub_y, r_fator);
          end
        end

        default: begin
          ram_wren <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_replicacao_blocos.sv
//------------------------------------------------------------------------------
// Module      : tb_replicacao_blocos
// Description : Directed self-checking bench for replicacao_blocos. Uses a
//               reduced 8x6 source image so that every zoom factor runs fully.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_replicacao_blocos;

  localparam int L   = 8;
  localparam int A   = 6;
  localparam int LAT = 2;
  localparam int N   = L * A;
  localparam int MAXW = N * 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  fator;
  logic [7:0]  pixel_rom;
  logic [18:0] rom_addr;
  logic [18:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic        erro;

  int checks   = 0;
  int failures = 0;
  bit written [0:MAXW-1];

  replicacao_blocos #(.LARGURA(L), .ALTURA(A), .ROM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fator      (fator),
    .pixel_rom  (pixel_rom),
    .rom_addr   (rom_addr),
    .ram_wraddr (ram_wraddr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .done       (done),
    .erro       (erro)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [18:0] a);
    logic [18:0] t;
    t = a * 19'd7 + 19'd3;
    return t[7:0];
  endfunction

  // Two-cycle ROM: data for an address is valid at the second edge after it changes.
  always @(posedge clk) pixel_rom <= rom_val(rom_addr);

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    fator = 3'd0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || erro !== 1'b0 ||
        rom_addr !== 19'd0 || ram_wraddr !== 19'd0 || ram_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: wren=%b busy=%b done=%b erro=%b rom=%0d wa=%0d d=%0d required all 0",
               ram_wren, busy, done, erro, rom_addr, ram_wraddr, ram_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: wren=%b busy=%b done=%b required 0 0 0", ram_wren, busy, done);
    end
  endtask

  // Starts a run from the current negedge and checks every write against
  // the block-order model. The task ends on the negedge where done is seen.
  task automatic run_image(input int f, input bit disturb, input string tag);
    int n, k, total, exp_cyc, px, s, idx;
    logic [18:0] exp_addr;
    logic [7:0]  exp_data;
    bit seen_done;
    total   = N * f * f;
    exp_cyc = N * (1 + LAT + f * f);
    for (int i = 0; i < MAXW; i++) written[i] = 1'b0;
    fator = 3'(f);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || erro !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: done=%b busy=%b erro=%b required done=0 busy=1 erro=0",
               tag, done, busy, erro);
    end
    n = 0;
    k = 0;
    seen_done = 1'b0;
    while (n < exp_cyc + 100 && !seen_done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (disturb && n == 20) begin
        start = 1'b1;
        fator = ~3'(f);
      end
      if (disturb && n == 21) start = 1'b0;
      if (ram_wren === 1'b1) begin
        px = k / (f * f);
        s  = k % (f * f);
        exp_addr = 19'(((px / L) * f + s / f) * (L * f) + (px % L) * f + s % f);
        exp_data = rom_val(19'(px));
        checks++;
        if (ram_wraddr !== exp_addr || ram_data !== exp_data) begin
          failures++;
          $display("FAIL %s_write%0d: addr=%0d data=%0d required addr=%0d data=%0d",
                   tag, k, ram_wraddr, ram_data, exp_addr, exp_data);
        end
        idx = int'(ram_wraddr);
        checks++;
        if (idx >= total || written[idx]) begin
          failures++;
          $display("FAIL %s_unique: addr=%0d repeated or out of range, required new addr below %0d",
                   tag, idx, total);
        end else begin
          written[idx] = 1'b1;
        end
        if (f == 1) begin
          checks++;
          if (ram_wraddr !== rom_addr) begin
            failures++;
            $display("FAIL %s_copy_addr: wraddr=%0d required rom_addr=%0d", tag, ram_wraddr, rom_addr);
          end
        end
        k++;
      end
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done || n != exp_cyc) begin
      failures++;
      $display("FAIL %s_cycles: done_seen=%0d cycles=%0d required cycles=%0d", tag, seen_done, n, exp_cyc);
    end
    checks++;
    if (k != total) begin
      failures++;
      $display("FAIL %s_writes: count=%0d required %0d", tag, k, total);
    end
    checks++;
    if (busy !== 1'b0 || erro !== 1'b0) begin
      failures++;
      $display("FAIL %s_end_flags: busy=%b erro=%b required 0 0", tag, busy, erro);
    end
  endtask

  task automatic test_bad_fator(input logic [2:0] f);
    int n, pulses;
    fator = f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    pulses = 0;
    while (n < 10 && done !== 1'b1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ram_wren === 1'b1) pulses++;
    end
    repeat (3) begin
      @(negedge clk);
      if (ram_wren === 1'b1) pulses++;
    end
    checks++;
    if (n != 1 || done !== 1'b1 || erro !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_fator%0d: cycles=%0d done=%b erro=%b busy=%b required 1 1 1 0",
               f, n, done, erro, busy);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL bad_fator%0d_wren: pulses=%0d required 0", f, pulses);
    end
  endtask

  task automatic test_reset_mid_write();
    int n, pulses;
    fator = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 50 && ram_wren !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ram_wren !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach_write: wren=%b required 1", ram_wren);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: wren=%b busy=%b done=%b required 0 0 0", ram_wren, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ram_wren === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: pulses=%0d busy=%b required 0 0", pulses, busy);
    end
    run_image(3, 1'b0, "after_reset_f3");
  endtask

  task automatic test_back_to_back();
    run_image(2, 1'b0, "b2b_first");
    run_image(2, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    run_image(2, 1'b0, "f2");
    run_image(4, 1'b0, "f4");
    test_bad_fator(3'd0);
    test_bad_fator(3'd5);
    run_image(2, 1'b0, "f2_after_erro");
    run_image(1, 1'b0, "f1");
    run_image(2, 1'b1, "f2_disturbed");
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
